// File: rtl/lpc_frame_packer.sv
// Buffers LPC analysis frames (A1..A10, voiced, pitch count) and streams each
// one as twelve 16-bit words over a valid/ready port, counting overflow drops.
module lpc_frame_packer #(
    parameter int         DEPTH = 2,
    parameter logic [3:0] SYNC  = 4'hA
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_valid,
    input  logic [15:0] A1,
    input  logic [15:0] A2,
    input  logic [15:0] A3,
    input  logic [15:0] A4,
    input  logic [15:0] A5,
    input  logic [15:0] A6,
    input  logic [15:0] A7,
    input  logic [15:0] A8,
    input  logic [15:0] A9,
    input  logic [15:0] A10,
    input  logic        voiced,
    input  logic [15:0] freq_count,
    output logic [15:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_sof,
    output logic        out_eof,
    output logic [7:0]  drop_count,
    output logic        overflow,
    output logic [3:0]  level
);

    // Handshake: a word moves on any cycle with out_valid && out_ready; while
    // out_valid is high and out_ready low, out_data/out_sof/out_eof hold.

    localparam int         PW       = $clog2(DEPTH);
    localparam logic [3:0] LAST_W   = 4'd11;
    localparam logic [3:0] FULL_LVL = 4'(DEPTH);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_SEND = 1'b1;

    logic [15:0]   mem [DEPTH][12];
    logic [15:0]   cap_words [12];

    logic [0:0]    state, state_nxt;
    logic [3:0]    widx, widx_nxt;
    logic [PW-1:0] wr_ptr, rd_ptr, rd_nxt;
    logic [2:0]    seq;
    logic [3:0]    level_nxt;
    logic [15:0]   word_nxt;
    logic          xfer, last_xfer, full, cap_en, drop;

    always_comb begin
        cap_words[0]  = {SYNC, voiced, seq, 8'h00};
        cap_words[1]  = freq_count;
        cap_words[2]  = A1;
        cap_words[3]  = A2;
        cap_words[4]  = A3;
        cap_words[5]  = A4;
        cap_words[6]  = A5;
        cap_words[7]  = A6;
        cap_words[8]  = A7;
        cap_words[9]  = A8;
        cap_words[10] = A9;
        cap_words[11] = A10;
    end

    always_comb begin
        xfer      = out_valid && out_ready;
        last_xfer = xfer && (widx == LAST_W);
        full      = (level == FULL_LVL);
        // A slot freed by the final-word transfer can take a new frame this cycle.
        cap_en    = frame_valid && (!full || last_xfer);
        drop      = frame_valid && !cap_en;
        level_nxt = level + {3'd0, cap_en} - {3'd0, last_xfer};
        rd_nxt    = last_xfer ? rd_ptr + 1'b1 : rd_ptr;

        state_nxt = state;
        widx_nxt  = widx;
        if (state == S_IDLE) begin
            if (level != 4'd0) begin
                state_nxt = S_SEND;
                widx_nxt  = 4'd0;
            end
        end else if (xfer) begin
            if (last_xfer) begin
                widx_nxt = 4'd0;
                if (level_nxt == 4'd0) state_nxt = S_IDLE;
            end else begin
                widx_nxt = widx + 4'd1;
            end
        end

        // The next frame may be the one landing in its slot this very cycle.
        if (cap_en && (rd_nxt == wr_ptr)) word_nxt = cap_words[widx_nxt];
        else                              word_nxt = mem[rd_nxt][widx_nxt];
    end

    always_ff @(posedge clk) begin
        if (!rst && cap_en) begin
            for (int i = 0; i < 12; i++) mem[wr_ptr][i] <= cap_words[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            widx       <= 4'd0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            seq        <= 3'd0;
            level      <= 4'd0;
            drop_count <= 8'd0;
            overflow   <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= 16'h0000;
            out_sof    <= 1'b0;
            out_eof    <= 1'b0;
        end else begin
            state  <= state_nxt;
            widx   <= widx_nxt;
            rd_ptr <= rd_nxt;
            level  <= level_nxt;
            if (frame_valid) seq <= seq + 3'd1;
            if (cap_en) wr_ptr <= wr_ptr + 1'b1;
            if (drop) begin
                overflow <= 1'b1;
                if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
            end
            out_valid <= (state_nxt == S_SEND);
            out_data  <= (state_nxt == S_SEND) ? word_nxt : 16'h0000;
            out_sof   <= (state_nxt == S_SEND) && (widx_nxt == 4'd0);
            out_eof   <= (state_nxt == S_SEND) && (widx_nxt == LAST_W);
        end
    end

endmodule

// File: tb/tb_lpc_frame_packer.sv
// Randomised bench for lpc_frame_packer: a frame-queue model of the output
// stream is compared against the DUT every cycle, plus fixed literal checks.
module tb_lpc_frame_packer;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_valid = 1'b0;
    logic        voiced = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] a [10];
    logic [15:0] freq_count = 16'h0000;
    logic [15:0] out_data;
    logic        out_valid, out_sof, out_eof, overflow;
    logic [7:0]  drop_count;
    logic [3:0]  level;

    lpc_frame_packer #(.DEPTH(DEPTH), .SYNC(4'hA)) dut (
        .clk(clk), .rst(rst), .frame_valid(frame_valid),
        .A1(a[0]), .A2(a[1]), .A3(a[2]), .A4(a[3]), .A5(a[4]),
        .A6(a[5]), .A7(a[6]), .A8(a[7]), .A9(a[8]), .A10(a[9]),
        .voiced(voiced), .freq_count(freq_count),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_sof(out_sof), .out_eof(out_eof), .drop_count(drop_count),
        .overflow(overflow), .level(level)
    );

    always #10 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: bound expired at %0t", name, $time);
    endtask

    // Model: the words the sink must still receive, in order.
    logic [15:0] exp_q [$];
    logic [15:0] seen_q [$];
    logic [15:0] hdr_q [$];
    int          m_drops = 0;
    logic        m_ovf = 1'b0;
    logic [2:0]  m_seq = 3'd0;
    int          occ_prev = 0;
    logic        prev_stall = 1'b0;
    logic [15:0] prev_data = 16'h0000;
    logic        checking = 1'b0;
    int          xfer_total = 0;
    int          ready_mode = 3;
    int          ph = 0;

    always @(negedge clk) begin
        int   sz, occ;
        logic xfer, freed;
        if (checking) begin
            sz  = exp_q.size();
            occ = (sz + 11) / 12;
            chk("level", 32'(level), 32'(occ));
            chk("drop_count", 32'(drop_count), 32'(m_drops));
            chk("overflow", 32'(overflow), 32'(m_ovf));
            chk("out_valid", 32'(out_valid), 32'(occ > 0 && occ_prev > 0));
            if (prev_stall) chk("stall_hold", 32'({out_valid, out_data}), 32'({1'b1, prev_data}));
            if (out_valid && sz > 0) begin
                chk("out_data", 32'(out_data), 32'(exp_q[0]));
                chk("out_sof", 32'(out_sof), 32'(sz % 12 == 0));
                chk("out_eof", 32'(out_eof), 32'(sz % 12 == 1));
            end
            xfer       = out_valid && out_ready && sz > 0;
            freed      = xfer && (sz % 12 == 1);
            prev_stall = out_valid && !out_ready && !rst;
            prev_data  = out_data;
            if (xfer) begin
                void'(exp_q.pop_front());
                seen_q.push_back(out_data);
                if (out_sof) hdr_q.push_back(out_data);
                xfer_total++;
            end
            if (rst) begin
                exp_q.delete();
                m_drops    = 0;
                m_ovf      = 1'b0;
                m_seq      = 3'd0;
                occ_prev   = 0;
                prev_stall = 1'b0;
            end else begin
                if (frame_valid) begin
                    if (occ - int'(freed) < DEPTH) begin
                        exp_q.push_back({4'hA, voiced, m_seq, 8'h00});
                        exp_q.push_back(freq_count);
                        for (int i = 0; i < 10; i++) exp_q.push_back(a[i]);
                    end else begin
                        if (m_drops < 255) m_drops++;
                        m_ovf = 1'b1;
                    end
                    m_seq = m_seq + 3'd1;
                end
                occ_prev = occ;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: out_ready = 1'b1;
                1: begin
                    out_ready = (ph == 0 || ph == 3);
                    ph = (ph + 1) % 4;
                end
                2: out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic send_frame(input logic v, input logic [15:0] fc, input logic rnd);
        @(posedge clk);
        #1;
        if (rnd) for (int i = 0; i < 10; i++) a[i] = 16'($urandom);
        voiced      = v;
        freq_count  = fc;
        frame_valid = 1'b1;
        @(posedge clk);
        #1;
        frame_valid = 1'b0;
    endtask

    task automatic wait_drain();
        logic done;
        done = 1'b0;
        for (int i = 0; i < 600 && !done; i++) begin
            @(posedge clk);
            #2;
            if (exp_q.size() == 0 && !out_valid) done = 1'b1;
        end
        if (!done) timeout_fail("drain");
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        frame_valid = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int   base;
        logic found;
        for (int i = 0; i < 10; i++) a[i] = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        checking = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_sof_eof", 32'({out_sof, out_eof}), 32'd0);

        // Single frame with fixed contents.
        ready_mode = 0;
        seen_q.delete();
        a[0] = 16'h7000; a[1] = 16'hF000; a[2] = 16'h0100;
        for (int i = 3; i < 10; i++) a[i] = 16'(i + 1);
        send_frame(1'b1, 16'd80, 1'b0);
        wait_drain();
        chk("single_count", 32'(seen_q.size()), 32'd12);
        if (seen_q.size() == 12) begin
            chk("single_w0", 32'(seen_q[0]), 32'h0000A800);
            chk("single_w1", 32'(seen_q[1]), 32'h00000050);
            chk("single_w2", 32'(seen_q[2]), 32'h00007000);
            chk("single_w11", 32'(seen_q[11]), 32'h0000000A);
        end

        // Backpressure 1,0,0,1.
        ready_mode = 1;
        seen_q.delete();
        send_frame(1'b0, 16'($urandom), 1'b1);
        wait_drain();
        chk("bp_count", 32'(seen_q.size()), 32'd12);

        // Overflow with the sink stalled.
        do_reset();
        ready_mode = 3;
        hdr_q.delete();
        for (int i = 0; i < 3; i++) send_frame(1'($urandom), 16'($urandom), 1'b1);
        repeat (3) @(posedge clk);
        #1;
        chk("ovf_level", 32'(level), 32'd2);
        chk("ovf_drops", 32'(drop_count), 32'd1);
        chk("ovf_flag", 32'(overflow), 32'd1);
        ready_mode = 0;
        wait_drain();
        send_frame(1'b1, 16'($urandom), 1'b1);
        wait_drain();
        chk("ovf_hdr_count", 32'(hdr_q.size()), 32'd3);
        if (hdr_q.size() == 3) begin
            chk("ovf_seq0", 32'(hdr_q[0][10:8]), 32'd0);
            chk("ovf_seq1", 32'(hdr_q[1][10:8]), 32'd1);
            chk("ovf_seq3", 32'(hdr_q[2][10:8]), 32'd3);
        end

        // Sequence wrap over nine frames.
        do_reset();
        hdr_q.delete();
        for (int i = 0; i < 9; i++) begin
            send_frame(1'($urandom), 16'($urandom), 1'b1);
            wait_drain();
        end
        chk("wrap_count", 32'(hdr_q.size()), 32'd9);
        for (int i = 0; i < 9 && i < hdr_q.size(); i++)
            chk("wrap_seq", 32'(hdr_q[i][10:8]), 32'(i % 8));
        chk("wrap_drops", 32'(drop_count), 32'd0);

        // Capture in the same cycle as the final-word transfer of a full buffer.
        ready_mode = 3;
        send_frame(1'b0, 16'($urandom), 1'b1);
        send_frame(1'b1, 16'($urandom), 1'b1);
        ready_mode = 0;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(posedge clk);
            #1;
            if (out_valid && out_eof) found = 1'b1;
        end
        if (!found) timeout_fail("simul_eof");
        chk("simul_level", 32'(level), 32'd2);
        for (int i = 0; i < 10; i++) a[i] = 16'($urandom);
        freq_count  = 16'($urandom);
        frame_valid = 1'b1;
        @(posedge clk);
        #1;
        frame_valid = 1'b0;
        wait_drain();
        chk("simul_drops", 32'(drop_count), 32'd0);

        // Random traffic and random sink readiness.
        ready_mode = 2;
        for (int i = 0; i < 30; i++) begin
            send_frame(1'($urandom), 16'($urandom), 1'b1);
            repeat ($urandom_range(0, 15)) @(posedge clk);
        end
        wait_drain();

        // Reset after word 5 of a frame.
        ready_mode = 0;
        base = xfer_total;
        send_frame(1'b1, 16'($urandom), 1'b1);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (xfer_total >= base + 6) found = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        if (!found) timeout_fail("midreset_wait");
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_level", 32'(level), 32'd0);
        chk("midrst_drops", 32'(drop_count), 32'd0);
        hdr_q.delete();
        send_frame(1'b0, 16'($urandom), 1'b1);
        wait_drain();
        chk("midrst_hdr_count", 32'(hdr_q.size()), 32'd1);
        if (hdr_q.size() == 1) chk("midrst_w0", 32'(hdr_q[0]), 32'h0000A000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
